// File: rtl/dsp_pkg.sv
// Shared constants for the DSP voice scheduler: default geometry and the
// RAM arbiter state encoding.
package dsp_pkg;

    localparam int unsigned DEF_NUM_VOICES    = 8;
    localparam int unsigned DEF_SAMPLE_PERIOD = 768;
    localparam int unsigned DEF_SLOT_CYCLES   = 64;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_DATA  = 2'd2;

endpackage

// File: rtl/dsp_rr_arbiter.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping around, is returned one-hot.
module dsp_rr_arbiter #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned PTR_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic [NUM_VOICES-1:0] req_i,
    input  logic [PTR_W-1:0]      ptr_i,
    output logic [NUM_VOICES-1:0] winner_o,
    output logic                  valid_o
);

    // One spare bit so ptr + offset cannot overflow before the wrap.
    logic [PTR_W:0] idx;

    always_comb begin
        idx      = '0;
        winner_o = '0;
        valid_o  = 1'b0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            idx = {1'b0, ptr_i} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(NUM_VOICES)) begin
                idx = idx - (PTR_W + 1)'(NUM_VOICES);
            end
            if (!valid_o && req_i[idx[PTR_W-1:0]]) begin
                winner_o[idx[PTR_W-1:0]] = 1'b1;
                valid_o                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_voice_scheduler.sv
// Frame sequencer issuing per-voice advance pulses, plus a round-robin
// arbiter sharing one RAM read port among the voice decoders.
module dsp_voice_scheduler
    import dsp_pkg::*;
#(
    parameter int unsigned NUM_VOICES    = DEF_NUM_VOICES,
    parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int unsigned SLOT_CYCLES   = DEF_SLOT_CYCLES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_VOICES-1:0]    voice_req,
    input  logic [16*NUM_VOICES-1:0] voice_addr,
    output logic [NUM_VOICES-1:0]    voice_grant,
    output logic [NUM_VOICES-1:0]    voice_rvalid,
    output logic [7:0]               voice_rdata,
    output logic [15:0]              ram_address,
    output logic                     ram_read_request,
    input  logic [7:0]               ram_data,
    output logic [NUM_VOICES-1:0]    advance_trigger,
    output logic                     frame_start
);

    localparam int unsigned PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_VOICES-1:0] win_q, win_d;
    logic [15:0]           addr_q, addr_d;

    logic [NUM_VOICES-1:0] arb_winner;
    logic                  arb_valid;
    logic [15:0]           sel_addr;
    logic [PTR_W-1:0]      next_ptr;
    logic                  in_issue;
    logic                  in_data;

    dsp_rr_arbiter #(
        .NUM_VOICES (NUM_VOICES),
        .PTR_W      (PTR_W)
    ) u_rr_arbiter (
        .req_i    (voice_req),
        .ptr_i    (ptr_q),
        .winner_o (arb_winner),
        .valid_o  (arb_valid)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == CNT_W'(SAMPLE_PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        frame_start     = reset && enable && (cnt_q == '0);
        advance_trigger = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            advance_trigger[v] = reset && enable && (cnt_q == CNT_W'(v * SLOT_CYCLES));
        end
    end

    always_comb begin
        sel_addr = '0;
        next_ptr = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (arb_winner[v]) begin
                sel_addr = voice_addr[16*v +: 16];
                next_ptr = (v == NUM_VOICES - 1) ? '0 : PTR_W'(v + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        addr_d  = addr_q;
        case (state_q)
            ARB_IDLE: begin
                if (arb_valid) begin
                    state_d = ARB_ISSUE;
                    win_d   = arb_winner;
                    addr_d  = sel_addr;
                    ptr_d   = next_ptr;
                end
            end
            ARB_ISSUE: state_d = ARB_DATA;
            ARB_DATA:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            addr_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs are forced low during reset, which also kills an in-flight read.
    assign in_issue = reset && (state_q == ARB_ISSUE);
    assign in_data  = reset && (state_q == ARB_DATA);

    assign ram_read_request = in_issue;
    assign voice_grant      = in_issue ? win_q : '0;
    assign voice_rvalid     = in_data ? win_q : '0;
    assign voice_rdata      = in_data ? ram_data : '0;
    assign ram_address      = reset ? addr_q : '0;

endmodule
